// File: rtl/image_axis_master_fifo.sv
// image_axis_master_fifo
//   AXI4-Stream master output stage: a first-word-fall-through FIFO between
//   the pixel pipeline (producer) and the DMA S2MM port. TLAST is either
//   taken from the producer's last_in or generated from a programmable
//   frame length. Status outputs report occupancy, end of frame and drops.
//
// Ports
//   M_AXIS_ACLK, M_AXIS_ARESETN   clock, asynchronous active-low reset
//   M_AXIS_TVALID/TDATA/TSTRB/TLAST/TREADY   AXI4-Stream master
//   data_in, valid_in, last_in    producer word, valid, end-of-frame
//   ready_out                     FIFO can accept a word this cycle
//   tlast_mode                    0: pass last_in, 1: generate from frame_len
//   frame_len                     beats per frame (0 treated as 1)
//   clr_err                       clears err_drop
//   fifo_level                    current occupancy
//   frame_done                    one-cycle pulse after a TLAST beat is read
//   err_drop                      sticky: word offered while ready_out=0
module image_axis_master_fifo #(
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_FIFO_DEPTH         = 16,
  parameter int unsigned C_LEN_WIDTH          = 24
) (
  input  logic                                    M_AXIS_ACLK,
  input  logic                                    M_AXIS_ARESETN,
  output logic                                    M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]         M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]       M_AXIS_TSTRB,
  output logic                                    M_AXIS_TLAST,
  input  logic                                    M_AXIS_TREADY,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]         data_in,
  input  logic                                    valid_in,
  input  logic                                    last_in,
  output logic                                    ready_out,
  input  logic                                    tlast_mode,
  input  logic [C_LEN_WIDTH-1:0]                  frame_len,
  input  logic                                    clr_err,
  output logic [$clog2(C_FIFO_DEPTH+1)-1:0]       fifo_level,
  output logic                                    frame_done,
  output logic                                    err_drop
);

  localparam int unsigned PTR_W = $clog2(C_FIFO_DEPTH);
  localparam int unsigned LVL_W = $clog2(C_FIFO_DEPTH + 1);

  // Storage (no reset needed: entries are only visible through level_q)
  logic [C_M_AXIS_TDATA_WIDTH-1:0] mem_data_q [C_FIFO_DEPTH];
  logic [C_FIFO_DEPTH-1:0]         mem_last_q;

  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic [C_LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [C_LEN_WIDTH-1:0] len_q, len_d;
  logic                   mode_q, mode_d;
  logic                   frame_done_q, frame_done_d;
  logic                   err_q, err_d;

  logic                   wr_en, rd_en;
  logic                   frame_start;
  logic                   mode_eff;
  logic [C_LEN_WIDTH-1:0] len_eff;
  logic                   gen_last;
  logic                   last_wr;

  // Write acceptance depends only on the registered level, never on TREADY.
  assign ready_out     = M_AXIS_ARESETN && (level_q < LVL_W'(C_FIFO_DEPTH));
  assign wr_en         = valid_in && ready_out;

  assign M_AXIS_TVALID = (level_q != '0);
  assign rd_en         = M_AXIS_TVALID && M_AXIS_TREADY;
  assign M_AXIS_TDATA  = M_AXIS_TVALID ? mem_data_q[rd_ptr_q] : '0;
  assign M_AXIS_TLAST  = M_AXIS_TVALID && mem_last_q[rd_ptr_q];
  assign M_AXIS_TSTRB  = '1;

  assign fifo_level    = level_q;
  assign frame_done    = frame_done_q;
  assign err_drop      = err_q;

  // Mode and length are latched on the first beat of a frame (cnt_q==0);
  // on that beat the live inputs are used directly. In pass-through mode
  // cnt_q stays 0, so the mode is effectively re-sampled every beat.
  always_comb begin
    frame_start = (cnt_q == '0);
    mode_eff    = frame_start ? tlast_mode : mode_q;
    if (frame_start) begin
      len_eff = (frame_len == '0) ? C_LEN_WIDTH'(1) : frame_len;
    end else begin
      len_eff = len_q;
    end
    gen_last = (cnt_q == (len_eff - C_LEN_WIDTH'(1)));
    last_wr  = mode_eff ? gen_last : last_in;
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    mode_d       = mode_q;
    frame_done_d = rd_en && M_AXIS_TLAST;
    err_d        = (valid_in && !ready_out) || (err_q && !clr_err);

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (frame_start) begin
        len_d  = len_eff;
        mode_d = mode_eff;
      end
      if (mode_eff) begin
        cnt_d = gen_last ? '0 : cnt_q + C_LEN_WIDTH'(1);
      end
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({wr_en, rd_en})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      cnt_q        <= '0;
      len_q        <= '0;
      mode_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      mode_q       <= mode_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (wr_en) begin
      mem_data_q[wr_ptr_q] <= data_in;
      mem_last_q[wr_ptr_q] <= last_wr;
    end
  end

endmodule

// File: tb/tb_image_axis_master_fifo.sv
module tb_image_axis_master_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = 24;
  localparam int unsigned LVW   = $clog2(DEPTH + 1);

  logic            clk;
  logic            rst_n;
  logic            tvalid;
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tstrb;
  logic            tlast;
  logic            tready;
  logic [DW-1:0]   data_in;
  logic            valid_in;
  logic            last_in;
  logic            ready_out;
  logic            tlast_mode;
  logic [LW-1:0]   frame_len;
  logic            clr_err;
  logic [LVW-1:0]  fifo_level;
  logic            frame_done;
  logic            err_drop;

  logic            tready_man;
  logic            tready_rnd;
  logic            tready_mode;
  logic            exp_last_drv;

  assign tready = tready_mode ? tready_rnd : tready_man;

  image_axis_master_fifo #(
    .C_M_AXIS_TDATA_WIDTH(DW),
    .C_FIFO_DEPTH        (DEPTH),
    .C_LEN_WIDTH         (LW)
  ) dut (
    .M_AXIS_ACLK   (clk),
    .M_AXIS_ARESETN(rst_n),
    .M_AXIS_TVALID (tvalid),
    .M_AXIS_TDATA  (tdata),
    .M_AXIS_TSTRB  (tstrb),
    .M_AXIS_TLAST  (tlast),
    .M_AXIS_TREADY (tready),
    .data_in       (data_in),
    .valid_in      (valid_in),
    .last_in       (last_in),
    .ready_out     (ready_out),
    .tlast_mode    (tlast_mode),
    .frame_len     (frame_len),
    .clr_err       (clr_err),
    .fifo_level    (fifo_level),
    .frame_done    (frame_done),
    .err_drop      (err_drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tready_rnd = 1'b0;
    forever begin
      @(posedge clk);
      #1 tready_rnd = 1'($urandom_range(0, 1));
    end
  end

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t sb_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    fd_count = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, between active edges.
  logic          prev_rd_last;
  logic          prev_stall;
  logic [DW-1:0] prev_data;

  initial begin
    beat_t e;
    prev_rd_last = 1'b0;
    prev_stall   = 1'b0;
    prev_data    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete();
        prev_rd_last = 1'b0;
        prev_stall   = 1'b0;
      end else begin
        check("level", 64'(fifo_level), 64'(sb_q.size()));
        check("tvalid", 64'(tvalid), 64'(sb_q.size() != 0));
        check("frame_done", 64'(frame_done), 64'(prev_rd_last));
        if (frame_done) fd_count++;
        if (prev_stall) check("tdata_hold", 64'(tdata), 64'(prev_data));
        prev_rd_last = 1'b0;
        if (tvalid && tready) begin
          if (sb_q.size() == 0) begin
            check("unexpected_beat", 64'(1), 64'(0));
          end else begin
            e = sb_q.pop_front();
            check("tdata", 64'(tdata), 64'(e.d));
            check("tlast", 64'(tlast), 64'(e.l));
            prev_rd_last = e.l;
          end
        end
        prev_stall = tvalid && !tready;
        prev_data  = tdata;
        if (valid_in && ready_out) begin
          e.d = data_in;
          e.l = exp_last_drv;
          sb_q.push_back(e);
        end
      end
    end
  end

  // Offer a word only once ready_out is high, so no drop occurs.
  task automatic send(input logic [DW-1:0] d, input logic li, input logic el);
    int k;
    for (k = 0; k < 300; k++) begin
      if (ready_out) break;
      @(posedge clk);
      #1;
    end
    if (k == 300) check("send_timeout", 64'(0), 64'(1));
    data_in      = d;
    last_in      = li;
    exp_last_drv = el;
    valid_in     = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  // Offer a word for exactly one cycle regardless of ready_out.
  task automatic send_raw(input logic [DW-1:0] d, input logic li, input logic el);
    data_in      = d;
    last_in      = li;
    exp_last_drv = el;
    valid_in     = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 400; k++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("drain_empty", 64'(sb_q.size()), 64'(0));
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0;
    rst_n        = 1'b0;
    valid_in     = 1'b0;
    data_in      = '0;
    last_in      = 1'b0;
    tlast_mode   = 1'b0;
    frame_len    = LW'(4);
    clr_err      = 1'b0;
    tready_man   = 1'b0;
    tready_mode  = 1'b0;
    exp_last_drv = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 64'(tvalid), 64'(0));
    check("rst_tlast", 64'(tlast), 64'(0));
    check("rst_tdata", 64'(tdata), 64'(0));
    check("rst_level", 64'(fifo_level), 64'(0));
    check("rst_ready", 64'(ready_out), 64'(0));
    check("rst_fdone", 64'(frame_done), 64'(0));
    check("rst_err", 64'(err_drop), 64'(0));
    check("tstrb", 64'(tstrb), 64'(4'hF));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word, one-cycle latency
    tready_man = 1'b1;
    send(32'hA5A5_0001, 1'b0, 1'b0);
    check("t1_tvalid", 64'(tvalid), 64'(1));
    check("t1_tdata", 64'(tdata), 64'(32'hA5A5_0001));
    @(posedge clk);
    #1;
    check("t1_tvalid_after", 64'(tvalid), 64'(0));
    check("t1_level_after", 64'(fifo_level), 64'(0));

    // Fill to full under stall, 17th word dropped
    tready_man = 1'b0;
    for (int i = 0; i < 17; i++) send_raw(32'h1000 + 32'(i), 1'b0, 1'b0);
    check("t2_level_full", 64'(fifo_level), 64'(DEPTH));
    check("t2_ready_full", 64'(ready_out), 64'(0));
    check("t2_err_set", 64'(err_drop), 64'(1));
    clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    check("t2_err_clr", 64'(err_drop), 64'(0));
    tready_man = 1'b1;
    drain();

    // Generated TLAST, frame_len=4, random TREADY
    tlast_mode  = 1'b1;
    frame_len   = LW'(4);
    tready_mode = 1'b1;
    fd0 = fd_count;
    for (int i = 0; i < 12; i++) send(32'h2000 + 32'(i), 1'b0, (i % 4) == 3);
    drain();
    check("t3_fd_pulses", 64'(fd_count - fd0), 64'(3));
    check("t3_err", 64'(err_drop), 64'(0));
    tready_mode = 1'b0;

    // Pass-through TLAST on 3rd word
    tlast_mode = 1'b0;
    tready_man = 1'b1;
    for (int i = 0; i < 5; i++) send(32'h3000 + 32'(i), i == 2, i == 2);
    drain();

    // Full plus simultaneous read and valid_in
    tready_man = 1'b0;
    for (int i = 0; i < 16; i++) send(32'h4000 + 32'(i), 1'b0, 1'b0);
    check("t5_level_full", 64'(fifo_level), 64'(DEPTH));
    tready_man   = 1'b1;
    data_in      = 32'hDEAD_BEEF;
    exp_last_drv = 1'b0;
    valid_in     = 1'b1;
    #1;
    check("t5_ready_full_rd", 64'(ready_out), 64'(0));
    @(posedge clk);
    #1;
    valid_in   = 1'b0;
    tready_man = 1'b0;
    check("t5_err", 64'(err_drop), 64'(1));
    check("t5_ready_next", 64'(ready_out), 64'(1));
    check("t5_level_next", 64'(fifo_level), 64'(DEPTH - 1));
    clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    tready_man = 1'b1;
    drain();

    // Asynchronous reset mid-frame, then a fresh frame_len=2 frame
    tready_man = 1'b0;
    tlast_mode = 1'b1;
    frame_len  = LW'(8);
    for (int i = 0; i < 5; i++) send(32'h5000 + 32'(i), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_tvalid", 64'(tvalid), 64'(0));
    check("t6_level", 64'(fifo_level), 64'(0));
    check("t6_fdone", 64'(frame_done), 64'(0));
    check("t6_ready", 64'(ready_out), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    frame_len  = LW'(2);
    tready_man = 1'b1;
    fd0 = fd_count;
    for (int i = 0; i < 3; i++) send(32'h6000 + 32'(i), 1'b0, i == 1);
    drain();
    check("t6_fd_pulses", 64'(fd_count - fd0), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
